// File: rtl/phys_free_list_pkg.sv
// Shared parameters and types for the physical register file, used by the
// free list, rename table, retirement map and ROB.
//   NUM_PREGS  : total physical registers (power of two)
//   NUM_AREGS  : architectural registers, mapped to preg 0..NUM_AREGS-1 at reset
//   P_WIDTH    : physical register ID width
//   preg_id_t  : physical register ID
//   free_ptr_t : free-list pointer, index plus one wrap bit
package phys_free_list_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned P_WIDTH   = $clog2(NUM_PREGS);
  localparam int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int unsigned FL_PTR_W  = $clog2(FL_DEPTH) + 1;

  typedef logic [P_WIDTH-1:0]  preg_id_t;
  typedef logic [FL_PTR_W-1:0] free_ptr_t;

endpackage

// File: rtl/free_ptr_ctr.sv
// Wrap-bit pointer register for the free list (head, tail, commit head).
// Arithmetic wraps modulo 2**W. Load has priority over increment.
//   clk_i, rst_i : clock, synchronous active-high reset (to ResetVal)
//   inc_i        : advance pointer by one
//   load_i       : replace pointer with load_val_i
//   load_val_i   : value to load
//   ptr_o        : current pointer
module free_ptr_ctr
  import phys_free_list_pkg::*;
#(
  parameter int unsigned W        = FL_PTR_W,
  parameter logic [W-1:0] ResetVal = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= ResetVal;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/phys_free_list.sv
// Physical register free list: circular FIFO of free preg IDs.
// Dispatch pops from head, commit pushes the superseded mapping at tail, and
// commit_head tracks the oldest uncommitted allocation so a flush can return
// every speculative allocation by snapping head back in one cycle.
//   clk, rst      : clock, synchronous active-high reset
//   alloc_req     : dispatch wants a register
//   alloc_pd      : head entry, offered this cycle
//   alloc_ok      : alloc_pd valid; pop happens if alloc_req
//   commit_valid  : an allocating instruction commits
//   commit_old_pd : its previous mapping, returned to the pool
//   flush         : squash all uncommitted instructions
//   free_count    : free entries (tail - head)
//   empty         : free_count == 0
//   overflow_err  : sticky, push attempted while full
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int unsigned NUM_PREGS = phys_free_list_pkg::NUM_PREGS,
  parameter int unsigned NUM_AREGS = phys_free_list_pkg::NUM_AREGS,
  parameter int unsigned PW        = $clog2(NUM_PREGS),
  parameter int unsigned DEPTH     = NUM_PREGS - NUM_AREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_req,
  output logic [PW-1:0]            alloc_pd,
  output logic                     alloc_ok,
  input  logic                     commit_valid,
  input  logic [PW-1:0]            commit_old_pd,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   free_count,
  output logic                     empty,
  output logic                     overflow_err
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned PTRW = IW + 1;

  logic [PTRW-1:0] head_ptr, tail_ptr, commit_ptr, commit_ptr_next;
  logic [PW-1:0]   entry_q [DEPTH];
  logic            full, push, pop;
  logic            overflow_q;

  assign free_count = tail_ptr - head_ptr;
  assign empty      = (free_count == '0);
  assign full       = (free_count == PTRW'(DEPTH));
  assign alloc_ok   = !empty;
  assign alloc_pd   = entry_q[head_ptr[IW-1:0]];

  // Fullness is judged before this cycle's pop, so a push while full is dropped.
  assign push = commit_valid && !full;
  assign pop  = alloc_req && alloc_ok && !flush;

  // Flush restores head to the commit point including this cycle's commit.
  assign commit_ptr_next = commit_ptr + PTRW'(push);

  free_ptr_ctr #(
    .W        (PTRW),
    .ResetVal ('0)
  ) u_head (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (pop),
    .load_i     (flush),
    .load_val_i (commit_ptr_next),
    .ptr_o      (head_ptr)
  );

  // Tail starts one full lap ahead of head: list full at reset.
  free_ptr_ctr #(
    .W        (PTRW),
    .ResetVal (PTRW'(DEPTH))
  ) u_tail (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (push),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (tail_ptr)
  );

  free_ptr_ctr #(
    .W        (PTRW),
    .ResetVal ('0)
  ) u_commit_head (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (push),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (commit_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= PW'(NUM_AREGS + i);
      end
    end else if (push) begin
      entry_q[tail_ptr[IW-1:0]] <= commit_old_pd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (commit_valid && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic      clk;
  logic      rst;
  logic      alloc_req;
  preg_id_t  alloc_pd;
  logic      alloc_ok;
  logic      commit_valid;
  preg_id_t  commit_old_pd;
  logic      flush;
  logic [5:0] free_count;
  logic      empty;
  logic      overflow_err;

  int n_checks = 0;
  int n_errors = 0;
  int inv_viol = 0;
  logic [5:0] inv_dh, inv_dt;
  preg_id_t model_q[$];

  phys_free_list dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req     (alloc_req),
    .alloc_pd      (alloc_pd),
    .alloc_ok      (alloc_ok),
    .commit_valid  (commit_valid),
    .commit_old_pd (commit_old_pd),
    .flush         (flush),
    .free_count    (free_count),
    .empty         (empty),
    .overflow_err  (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // commit_head <= head <= tail, measured as distances from commit_head.
  always @(negedge clk) begin
    if (!rst) begin
      inv_dh = dut.head_ptr - dut.commit_ptr;
      inv_dt = dut.tail_ptr - dut.commit_ptr;
      if (inv_dh > inv_dt || inv_dt > 6'd32) inv_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req     = 1'b0;
    commit_valid  = 1'b0;
    commit_old_pd = '0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pd"},    32'(alloc_pd), 32);
    check_eq({tag, "_ok"},    32'(alloc_ok), 1);
    check_eq({tag, "_cnt"},   32'(free_count), 32);
    check_eq({tag, "_empty"}, 32'(empty), 0);
    check_eq({tag, "_ovf"},   32'(overflow_err), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // 1: drain the list
    do_reset();
    check_reset_state("rst");
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      check_eq("s1_pd", 32'(alloc_pd), 32'(32 + i));
      tick();
    end
    alloc_req = 1'b0;
    check_eq("s1_empty", 32'(empty), 1);
    check_eq("s1_ok",    32'(alloc_ok), 0);
    check_eq("s1_cnt",   32'(free_count), 0);
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    check_eq("s1_head_hold", 32'(dut.head_ptr), 32);
    check_eq("s1_cnt_hold",  32'(free_count), 0);

    // 2: commit into an empty list; no same-cycle bypass
    commit_valid  = 1'b1;
    commit_old_pd = 6'd5;
    #1;
    check_eq("s2_ok_same", 32'(alloc_ok), 0);
    tick();
    idle_inputs();
    check_eq("s2_ok",  32'(alloc_ok), 1);
    check_eq("s2_pd",  32'(alloc_pd), 5);
    check_eq("s2_cnt", 32'(free_count), 1);

    // 3: alloc 4, commit 1, flush
    do_reset();
    alloc_req = 1'b1;
    repeat (4) tick();
    idle_inputs();
    commit_valid  = 1'b1;
    commit_old_pd = 6'd7;
    tick();
    idle_inputs();
    check_eq("s3_cnt_pre", 32'(free_count), 29);
    flush = 1'b1;
    tick();
    idle_inputs();
    check_eq("s3_cnt", 32'(free_count), 32);
    check_eq("s3_pd",  32'(alloc_pd), 33);

    // 4: flush + alloc + commit in one cycle
    do_reset();
    alloc_req = 1'b1;
    repeat (3) tick();
    alloc_req     = 1'b1;
    commit_valid  = 1'b1;
    commit_old_pd = 6'd9;
    flush         = 1'b1;
    tick();
    idle_inputs();
    check_eq("s4_head",   32'(dut.head_ptr), 1);
    check_eq("s4_chead",  32'(dut.commit_ptr), 1);
    check_eq("s4_cnt",    32'(free_count), 32);
    check_eq("s4_pd",     32'(alloc_pd), 33);
    alloc_req = 1'b1;
    repeat (31) tick();
    alloc_req = 1'b0;
    check_eq("s4_entry0", 32'(alloc_pd), 9);
    check_eq("s4_cnt1",   32'(free_count), 1);

    // 5: steady-state alloc + commit against a FIFO model
    do_reset();
    model_q.delete();
    for (int i = 0; i < 32; i++) model_q.push_back(preg_id_t'(32 + i));
    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("s5_pre_pd", 32'(alloc_pd), 32'(model_q[0]));
      tick();
      void'(model_q.pop_front());
    end
    for (int i = 0; i < 100; i++) begin
      alloc_req     = 1'b1;
      commit_valid  = 1'b1;
      commit_old_pd = preg_id_t'((i * 7 + 3) % 64);
      check_eq("s5_pd",  32'(alloc_pd), 32'(model_q[0]));
      check_eq("s5_cnt", 32'(free_count), 28);
      tick();
      void'(model_q.pop_front());
      model_q.push_back(commit_old_pd);
    end
    idle_inputs();
    check_eq("s5_cnt_end", 32'(free_count), 28);

    // 6: overflow from full, sticky, cleared by reset
    do_reset();
    commit_valid  = 1'b1;
    commit_old_pd = 6'd11;
    tick();
    idle_inputs();
    check_eq("s6_ovf",  32'(overflow_err), 1);
    check_eq("s6_tail", 32'(dut.tail_ptr), 32);
    check_eq("s6_pd",   32'(alloc_pd), 32);
    check_eq("s6_cnt",  32'(free_count), 32);
    alloc_req = 1'b1;
    tick();
    idle_inputs();
    check_eq("s6_sticky", 32'(overflow_err), 1);
    // reset wins over every other input
    alloc_req     = 1'b1;
    commit_valid  = 1'b1;
    commit_old_pd = 6'd12;
    flush         = 1'b1;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check_reset_state("s6_rst");

    check_eq("invariant", 32'(inv_viol), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
